// File: rtl/i2c_slave.sv
// I2C target with a 7-bit address. Reads return a 16-bit word latched at address match;
// written bytes are reported on rx_data. scl/sda are oversampled on clk and never stretched.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h48,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        scl,
  inout  wire         sda,
  input  logic [15:0] data_in,
  output logic        busy,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rd_done
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, TX_BYTE, TX_ACK, RX_BYTE, RX_ACK, WAIT_STOP
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync_reg, sda_sync_reg;
  logic                   scl_d_reg, sda_d_reg;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, start_det, stop_det;

  state_t      state_reg, state_next;
  logic [3:0]  bit_cnt_reg, bit_cnt_next;
  logic [7:0]  shift_reg, shift_next;
  logic [15:0] tx_word_reg, tx_word_next;
  logic [6:0]  tx_shift_reg, tx_shift_next;
  logic        byte_sel_reg, byte_sel_next;
  logic        rw_reg, rw_next;
  logic        sda_oe_reg, sda_oe_next;
  logic        busy_reg, busy_next;
  logic [7:0]  rx_data_reg, rx_data_next;
  logic        rx_valid_reg, rx_valid_next;
  logic        rd_done_reg, rd_done_next;
  logic [7:0]  next_byte;

  assign scl_s     = scl_sync_reg[SYNC_STAGES-1];
  assign sda_s     = sda_sync_reg[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_d_reg;
  assign scl_fall  = ~scl_s & scl_d_reg;
  assign start_det = scl_s & sda_d_reg & ~sda_s;
  assign stop_det  = scl_s & ~sda_d_reg & sda_s;
  // byte_sel_reg = 1 means the high byte goes out next, so reads wrap hi, lo, hi, ...
  assign next_byte = byte_sel_reg ? tx_word_reg[15:8] : tx_word_reg[7:0];

  assign sda      = sda_oe_reg ? 1'b0 : 1'bz;
  assign busy     = busy_reg;
  assign rx_data  = rx_data_reg;
  assign rx_valid = rx_valid_reg;
  assign rd_done  = rd_done_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      scl_sync_reg <= '1;
      sda_sync_reg <= '1;
      scl_d_reg    <= 1'b1;
      sda_d_reg    <= 1'b1;
      state_reg    <= IDLE;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      tx_word_reg  <= '0;
      tx_shift_reg <= '0;
      byte_sel_reg <= 1'b0;
      rw_reg       <= 1'b0;
      sda_oe_reg   <= 1'b0;
      busy_reg     <= 1'b0;
      rx_data_reg  <= '0;
      rx_valid_reg <= 1'b0;
      rd_done_reg  <= 1'b0;
    end else begin
      scl_sync_reg <= {scl_sync_reg[SYNC_STAGES-2:0], scl};
      sda_sync_reg <= {sda_sync_reg[SYNC_STAGES-2:0], sda};
      scl_d_reg    <= scl_s;
      sda_d_reg    <= sda_s;
      state_reg    <= state_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      tx_word_reg  <= tx_word_next;
      tx_shift_reg <= tx_shift_next;
      byte_sel_reg <= byte_sel_next;
      rw_reg       <= rw_next;
      sda_oe_reg   <= sda_oe_next;
      busy_reg     <= busy_next;
      rx_data_reg  <= rx_data_next;
      rx_valid_reg <= rx_valid_next;
      rd_done_reg  <= rd_done_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    tx_word_next  = tx_word_reg;
    tx_shift_next = tx_shift_reg;
    byte_sel_next = byte_sel_reg;
    rw_next       = rw_reg;
    sda_oe_next   = sda_oe_reg;
    busy_next     = busy_reg;
    rx_data_next  = rx_data_reg;
    rx_valid_next = 1'b0;
    rd_done_next  = 1'b0;

    // Bus conditions override whatever the byte engine is doing.
    if (start_det) begin
      state_next   = ADDR;
      bit_cnt_next = '0;
      shift_next   = '0;
      sda_oe_next  = 1'b0;
      busy_next    = 1'b0;
    end else if (stop_det) begin
      state_next   = IDLE;
      bit_cnt_next = '0;
      sda_oe_next  = 1'b0;
      busy_next    = 1'b0;
    end else begin
      case (state_reg)
        ADDR: begin
          if (scl_rise && bit_cnt_reg < 4'd8) begin
            shift_next   = {shift_reg[6:0], sda_s};
            bit_cnt_next = bit_cnt_reg + 4'd1;
          end else if (scl_fall && bit_cnt_reg == 4'd8) begin
            bit_cnt_next = '0;
            if (shift_reg[7:1] == SLAVE_ADDR) begin
              state_next   = ADDR_ACK;
              sda_oe_next  = 1'b1;
              busy_next    = 1'b1;
              tx_word_next = data_in;
              rw_next      = shift_reg[0];
            end else begin
              state_next = WAIT_STOP;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_rise) begin
            bit_cnt_next = 4'd1;
          end else if (scl_fall && bit_cnt_reg == 4'd1) begin
            bit_cnt_next = '0;
            if (rw_reg) begin
              state_next    = TX_BYTE;
              tx_shift_next = tx_word_reg[14:8];
              sda_oe_next   = ~tx_word_reg[15];
              byte_sel_next = 1'b0;
            end else begin
              state_next  = RX_BYTE;
              sda_oe_next = 1'b0;
              shift_next  = '0;
            end
          end
        end
        TX_BYTE: begin
          if (scl_rise) begin
            bit_cnt_next = bit_cnt_reg + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_reg == 4'd8) begin
              state_next   = TX_ACK;
              bit_cnt_next = '0;
              sda_oe_next  = 1'b0;
            end else begin
              sda_oe_next   = ~tx_shift_reg[6];
              tx_shift_next = {tx_shift_reg[5:0], 1'b0};
            end
          end
        end
        TX_ACK: begin
          if (scl_rise) begin
            if (!sda_s) begin
              bit_cnt_next = 4'd1;
            end else begin
              state_next   = WAIT_STOP;
              rd_done_next = 1'b1;
              busy_next    = 1'b0;
            end
          end else if (scl_fall && bit_cnt_reg == 4'd1) begin
            state_next    = TX_BYTE;
            bit_cnt_next  = '0;
            tx_shift_next = next_byte[6:0];
            sda_oe_next   = ~next_byte[7];
            byte_sel_next = ~byte_sel_reg;
          end
        end
        RX_BYTE: begin
          if (scl_rise && bit_cnt_reg < 4'd8) begin
            shift_next   = {shift_reg[6:0], sda_s};
            bit_cnt_next = bit_cnt_reg + 4'd1;
            if (bit_cnt_reg == 4'd7) begin
              rx_data_next  = {shift_reg[6:0], sda_s};
              rx_valid_next = 1'b1;
            end
          end else if (scl_fall && bit_cnt_reg == 4'd8) begin
            state_next   = RX_ACK;
            bit_cnt_next = '0;
            sda_oe_next  = 1'b1;
          end
        end
        RX_ACK: begin
          if (scl_rise) begin
            bit_cnt_next = 4'd1;
          end else if (scl_fall && bit_cnt_reg == 4'd1) begin
            state_next   = RX_BYTE;
            bit_cnt_next = '0;
            shift_next   = '0;
            sda_oe_next  = 1'b0;
          end
        end
        IDLE, WAIT_STOP: ;
        default: state_next = IDLE;
      endcase
    end
  end

endmodule
